// File: rtl/sw_sig_pkg.sv
// Shared types and helpers for the switch-signal conditioner.
// The optional SW_SIG_EDGE_LATCH_EN feature lives in the top level only.
package sw_sig_pkg;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;

    typedef enum logic {
        STABLE  = 1'b0,
        PENDING = 1'b1
    } deb_state_t;

    // The counter only ever holds 0..DEBOUNCE_CYCLES-1, so clog2 bits suffice (minimum 1).
    function automatic int cnt_width(input int debounce_cycles);
        int w;
        w = $clog2(debounce_cycles);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/sw_debounce_bit.sv
// One switch bit: synchronizer chain, STABLE/PENDING debounce FSM with counter,
// and registered one-cycle rise/fall pulses in the cycle the new level is accepted.
module sw_debounce_bit
    import sw_sig_pkg::*;
#(
    parameter int   DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int   SYNC_STAGES     = 2,
    parameter logic RESET_BIT       = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sw_raw,
    output logic       sw_sig,
    output logic       rise_pulse,
    output logic       fall_pulse,
    output deb_state_t state
);

    localparam int             CW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   s;

    deb_state_t             state_q;
    logic [CW-1:0]          cnt_q;
    logic                   sig_q;
    logic                   rise_q;
    logic                   fall_q;

    assign sync_d = {sync_q[SYNC_STAGES-2:0], sw_raw};
    assign s      = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= {SYNC_STAGES{RESET_BIT}};
        end else begin
            sync_q <= sync_d;
        end
    end

    // A change is accepted only after s differs from the accepted level on
    // DEBOUNCE_CYCLES consecutive edges; any agreement in between drops back to STABLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= STABLE;
            cnt_q   <= '0;
            sig_q   <= RESET_BIT;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            case (state_q)
                STABLE: begin
                    if (s != sig_q) begin
                        state_q <= PENDING;
                        cnt_q   <= CNT_ONE;
                    end else begin
                        cnt_q   <= '0;
                    end
                end
                PENDING: begin
                    if (s == sig_q) begin
                        state_q <= STABLE;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= STABLE;
                        cnt_q   <= '0;
                        sig_q   <= s;
                        rise_q  <= s;
                        fall_q  <= ~s;
                    end else begin
                        cnt_q   <= cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_q <= STABLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign sw_sig     = sig_q;
    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;
    assign state      = state_q;

endmodule

// File: rtl/sw_sig_conditioner.sv
// Conditions raw switch/key pins into clean synchronous levels for the PIO in_port.
// Define SW_SIG_EDGE_LATCH_EN to add sticky edge_flags with an edge_clear input.
module sw_sig_conditioner
    import sw_sig_pkg::*;
#(
    parameter int               WIDTH           = 2,
    parameter int               DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int               SYNC_STAGES     = 2,
    parameter logic [WIDTH-1:0] RESET_LEVEL     = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_sig,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse,
    output logic [WIDTH-1:0] busy
`ifdef SW_SIG_EDGE_LATCH_EN
    ,
    input  logic [WIDTH-1:0] edge_clear,
    output logic [WIDTH-1:0] edge_flags
`endif
);

    deb_state_t bit_state [WIDTH];

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        sw_debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .SYNC_STAGES     (SYNC_STAGES),
            .RESET_BIT       (RESET_LEVEL[i])
        ) u_bit (
            .clk        (clk),
            .reset      (reset),
            .sw_raw     (sw_raw[i]),
            .sw_sig     (sw_sig[i]),
            .rise_pulse (rise_pulse[i]),
            .fall_pulse (fall_pulse[i]),
            .state      (bit_state[i])
        );

        assign busy[i] = (bit_state[i] == PENDING);
    end

`ifdef SW_SIG_EDGE_LATCH_EN
    logic [WIDTH-1:0] edge_flags_q;
    logic [WIDTH-1:0] edge_flags_d;

    // A pulse arriving while software clears must not be lost, so set wins.
    assign edge_flags_d = (edge_flags_q & ~edge_clear) | rise_pulse | fall_pulse;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            edge_flags_q <= '0;
        end else begin
            edge_flags_q <= edge_flags_d;
        end
    end

    assign edge_flags = edge_flags_q;
`else
    // Default build carries no edge-capture state.
`endif

endmodule

// File: tb/tb_sw_sig_conditioner.sv
// Self-checking bench for sw_sig_conditioner (WIDTH=2, DEBOUNCE_CYCLES=4, SYNC_STAGES=2).
// Reference model: a level is accepted once the synchronized input disagrees with it on 4 consecutive edges.
module tb_sw_sig_conditioner;

  localparam int W    = 2;
  localparam int DEB  = 4;
  localparam int SYNC = 2;
  localparam logic [W-1:0] RL = '0;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] sw_raw;
  logic [W-1:0] sw_sig;
  logic [W-1:0] rise_pulse;
  logic [W-1:0] fall_pulse;
  logic [W-1:0] busy;
`ifdef SW_SIG_EDGE_LATCH_EN
  logic [W-1:0] edge_clear;
  logic [W-1:0] edge_flags;
`endif

  always #5 clk = ~clk;

  sw_sig_conditioner #(
    .WIDTH           (W),
    .DEBOUNCE_CYCLES (DEB),
    .SYNC_STAGES     (SYNC),
    .RESET_LEVEL     (RL)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .sw_raw     (sw_raw),
    .sw_sig     (sw_sig),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse),
    .busy       (busy)
`ifdef SW_SIG_EDGE_LATCH_EN
    ,
    .edge_clear (edge_clear),
    .edge_flags (edge_flags)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- reference model ----------------
  logic [W-1:0] m_pipe [SYNC];
  logic [W-1:0] m_sig, m_rise, m_fall, m_busy, m_flags;
  int           m_run [W];

  task automatic model_reset();
    for (int j = 0; j < SYNC; j++) m_pipe[j] = RL;
    m_sig   = RL;
    m_rise  = '0;
    m_fall  = '0;
    m_busy  = '0;
    m_flags = '0;
    for (int i = 0; i < W; i++) m_run[i] = 0;
  endtask

  task automatic model_edge();
    logic [W-1:0] s;
    logic [W-1:0] prev_pulse;
    if (reset) begin
      model_reset();
    end else begin
      s          = m_pipe[SYNC-1];
      prev_pulse = m_rise | m_fall;
      m_rise     = '0;
      m_fall     = '0;
      for (int i = 0; i < W; i++) begin
        if (s[i] != m_sig[i]) begin
          m_run[i] = m_run[i] + 1;
          if (m_run[i] == DEB) begin
            m_sig[i] = s[i];
            if (s[i]) m_rise[i] = 1'b1;
            else      m_fall[i] = 1'b1;
            m_run[i] = 0;
          end
        end else begin
          m_run[i] = 0;
        end
        m_busy[i] = (m_run[i] > 0);
      end
`ifdef SW_SIG_EDGE_LATCH_EN
      m_flags = (m_flags & ~edge_clear) | prev_pulse;
`else
      m_flags = '0;
`endif
      for (int j = SYNC - 1; j > 0; j--) m_pipe[j] = m_pipe[j-1];
      m_pipe[0] = sw_raw;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive(input logic [W-1:0] v);
    @(negedge clk);
    sw_raw = v;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      sw_raw = W'($urandom_range(0, 3));
      tick();
      n_checks++;
      if ({sw_sig, rise_pulse, fall_pulse, busy} !== 8'h00) begin
        n_fail++;
        $display("FAIL reset_hold c=%0d got sig=%b r=%b f=%b b=%b exp all 0", c, sw_sig, rise_pulse, fall_pulse, busy);
      end
    end
    @(negedge clk);
    reset  = 1'b0;
    sw_raw = '0;
    for (int c = 0; c < 6; c++) begin
      tick();
      n_checks++;
      if ({sw_sig, rise_pulse, fall_pulse, busy} !== 8'h00 || m_sig !== 2'b00) begin
        n_fail++;
        $display("FAIL reset_release c=%0d got sig=%b r=%b f=%b b=%b exp all 0", c, sw_sig, rise_pulse, fall_pulse, busy);
      end
    end
  endtask

  task automatic test_clean_press();
    logic exp_busy, exp_sig, exp_rise;
    drive(2'b01);
    for (int c = 1; c <= 10; c++) begin
      tick();
      exp_busy = (c >= 3 && c <= 5);
      exp_sig  = (c >= 6);
      exp_rise = (c == 6);
      n_checks++;
      if (busy[0] !== exp_busy || sw_sig[0] !== exp_sig || rise_pulse[0] !== exp_rise || fall_pulse !== 2'b00) begin
        n_fail++;
        $display("FAIL clean_press c=%0d got b=%b sig=%b r=%b f=%b exp b0=%b sig0=%b r0=%b f=00", c, busy, sw_sig, rise_pulse, fall_pulse, exp_busy, exp_sig, exp_rise);
      end
      n_checks++;
      if ({sw_sig, rise_pulse, fall_pulse, busy} !== {m_sig, m_rise, m_fall, m_busy}) begin
        n_fail++;
        $display("FAIL clean_press_model c=%0d got %b %b %b %b exp %b %b %b %b", c, sw_sig, rise_pulse, fall_pulse, busy, m_sig, m_rise, m_fall, m_busy);
      end
    end
  endtask

  task automatic test_glitch();
    drive(2'b11);
    for (int c = 1; c <= 12; c++) begin
      if (c == 4) begin
        @(negedge clk);
        sw_raw = 2'b01;
      end
      tick();
      n_checks++;
      if (sw_sig !== 2'b01 || rise_pulse !== 2'b00 || fall_pulse !== 2'b00) begin
        n_fail++;
        $display("FAIL glitch c=%0d got sig=%b r=%b f=%b exp sig=01 r=00 f=00", c, sw_sig, rise_pulse, fall_pulse);
      end
      n_checks++;
      if (busy !== m_busy) begin
        n_fail++;
        $display("FAIL glitch_busy c=%0d got %b exp %b", c, busy, m_busy);
      end
    end
    n_checks++;
    if (busy !== 2'b00) begin
      n_fail++;
      $display("FAIL glitch_end_busy got %b exp 00", busy);
    end
  endtask

  task automatic test_simultaneous();
    drive(2'b11);
    for (int c = 0; c < 8; c++) tick();
    n_checks++;
    if (sw_sig !== 2'b11) begin
      n_fail++;
      $display("FAIL simul_setup got sig=%b exp 11", sw_sig);
    end
    drive(2'b00);
    for (int c = 1; c <= 8; c++) begin
      tick();
      n_checks++;
      if (sw_sig !== ((c >= 6) ? 2'b00 : 2'b11) || fall_pulse !== ((c == 6) ? 2'b11 : 2'b00) || rise_pulse !== 2'b00) begin
        n_fail++;
        $display("FAIL simultaneous c=%0d got sig=%b f=%b r=%b", c, sw_sig, fall_pulse, rise_pulse);
      end
    end
  endtask

  task automatic test_reset_mid();
    drive(2'b11);
    for (int c = 0; c < 4; c++) tick();
    n_checks++;
    if (busy !== 2'b11) begin
      n_fail++;
      $display("FAIL reset_mid_pending got busy=%b exp 11", busy);
    end
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    #1;
    n_checks++;
    if ({sw_sig, rise_pulse, fall_pulse, busy} !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_mid_async got sig=%b r=%b f=%b b=%b exp all 0", sw_sig, rise_pulse, fall_pulse, busy);
    end
    tick();
    tick();
    @(negedge clk);
    reset = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      tick();
      n_checks++;
      if (sw_sig !== ((c >= 6) ? 2'b11 : 2'b00) || rise_pulse !== ((c == 6) ? 2'b11 : 2'b00) || fall_pulse !== 2'b00) begin
        n_fail++;
        $display("FAIL reset_mid_redebounce c=%0d got sig=%b r=%b f=%b", c, sw_sig, rise_pulse, fall_pulse);
      end
    end
  endtask

`ifdef SW_SIG_EDGE_LATCH_EN
  task automatic test_edge_latch();
    drive(2'b00);
    for (int c = 0; c < 10; c++) tick();
    @(negedge clk);
    edge_clear = 2'b11;
    tick();
    @(negedge clk);
    edge_clear = 2'b00;
    sw_raw     = 2'b01;
    n_checks++;
    if (edge_flags !== 2'b00) begin
      n_fail++;
      $display("FAIL latch_cleared got %b exp 00", edge_flags);
    end
    for (int c = 1; c <= 10; c++) begin
      tick();
      n_checks++;
      if (edge_flags !== ((c >= 7) ? 2'b01 : 2'b00)) begin
        n_fail++;
        $display("FAIL latch_rise c=%0d got %b exp %b", c, edge_flags, (c >= 7) ? 2'b01 : 2'b00);
      end
    end
    @(negedge clk);
    edge_clear = 2'b01;
    tick();
    @(negedge clk);
    edge_clear = 2'b00;
    n_checks++;
    if (edge_flags !== 2'b00) begin
      n_fail++;
      $display("FAIL latch_clear got %b exp 00", edge_flags);
    end
    sw_raw = 2'b00;
    for (int c = 1; c <= 6; c++) tick();
    n_checks++;
    if (fall_pulse !== 2'b01) begin
      n_fail++;
      $display("FAIL latch_fall_pulse got %b exp 01", fall_pulse);
    end
    @(negedge clk);
    edge_clear = 2'b01;
    tick();
    @(negedge clk);
    edge_clear = 2'b00;
    n_checks++;
    if (edge_flags !== 2'b01) begin
      n_fail++;
      $display("FAIL latch_set_wins got %b exp 01", edge_flags);
    end
    tick();
    n_checks++;
    if (edge_flags !== 2'b01) begin
      n_fail++;
      $display("FAIL latch_sticky got %b exp 01", edge_flags);
    end
  endtask
`endif

  task automatic test_random();
    int hold;
    for (int n = 0; n < 120; n++) begin
      @(negedge clk);
      sw_raw = W'($urandom_range(0, 3));
`ifdef SW_SIG_EDGE_LATCH_EN
      edge_clear = W'($urandom_range(0, 3));
`endif
      hold = $urandom_range(1, 7);
      for (int c = 0; c < hold; c++) begin
        tick();
        n_checks++;
        if ({sw_sig, rise_pulse, fall_pulse, busy} !== {m_sig, m_rise, m_fall, m_busy}) begin
          n_fail++;
          $display("FAIL random n=%0d got %b %b %b %b exp %b %b %b %b", n, sw_sig, rise_pulse, fall_pulse, busy, m_sig, m_rise, m_fall, m_busy);
        end
`ifdef SW_SIG_EDGE_LATCH_EN
        n_checks++;
        if (edge_flags !== m_flags) begin
          n_fail++;
          $display("FAIL random_flags n=%0d got %b exp %b", n, edge_flags, m_flags);
        end
`endif
      end
    end
  endtask

  initial begin
    reset  = 1'b1;
    sw_raw = '0;
`ifdef SW_SIG_EDGE_LATCH_EN
    edge_clear = '0;
`endif
    model_reset();
    test_reset();
    test_clean_press();
    test_glitch();
    test_simultaneous();
    test_reset_mid();
`ifdef SW_SIG_EDGE_LATCH_EN
    test_edge_latch();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
